// File: rtl/regfile_wport_ctrl.sv
// Write-port controller for the 32x32 register file: post-reset zeroing sequence,
// then arbitration between writeback and a small long-latency-unit write buffer.
module regfile_wport_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_DEFER  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     lu_valid,
    input  logic [ADDR_W-1:0]        lu_rd,
    input  logic [DATA_W-1:0]        lu_data,
    output logic                     lu_ready,
    output logic                     wb_stall,
    output logic                     init_busy,
    output logic [(2**ADDR_W)-1:0]   pending_mask,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_a3,
    output logic [DATA_W-1:0]        rf_wd3
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DEF_W    = $clog2(MAX_DEFER + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     init_cnt_q, init_cnt_d;
    logic [DEF_W-1:0]      defer_q, defer_d;

    logic [ADDR_W-1:0]     fifo_rd_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_W-1:0]     rd_d  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_d;
    logic [NUM_REGS-1:0]   mask_d;

    logic                  rf_we_d, wb_stall_d, init_busy_d;
    logic [ADDR_W-1:0]     rf_a3_d;
    logic [DATA_W-1:0]     rf_wd3_d;

    logic                  fifo_empty, fifo_full, push, push_store, pop, wb_req;

    // Buffer status and request qualification
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign lu_ready   = (state_q == ST_RUN) && !fifo_full;
    assign push       = lu_valid && lu_ready;
    assign push_store = push && (lu_rd != '0);
    assign wb_req     = !wb_stall && wb_we && (wb_rd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_INIT;
        else      state_q <= state_d;
    end

    // Next state, port selection and anti-starvation
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        defer_d     = defer_q;
        rf_we_d     = 1'b0;
        rf_a3_d     = rf_a3;
        rf_wd3_d    = rf_wd3;
        wb_stall_d  = 1'b0;
        init_busy_d = init_busy;
        pop         = 1'b0;
        case (state_q)
            ST_INIT: begin
                // counter wraps to 0 once x31 has been presented
                if (init_cnt_q == '0) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_a3_d    = init_cnt_q;
                    rf_wd3_d   = '0;
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (wb_req) begin
                    rf_we_d  = 1'b1;
                    rf_a3_d  = wb_rd;
                    rf_wd3_d = wb_data;
                    if (!fifo_empty) begin
                        defer_d    = defer_q + DEF_W'(1);
                        wb_stall_d = (defer_d == DEF_W'(MAX_DEFER));
                    end
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    rf_we_d  = 1'b1;
                    rf_a3_d  = fifo_rd_q[rd_ptr_q];
                    rf_wd3_d = fifo_data_q[rd_ptr_q];
                    defer_d  = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Next FIFO occupancy and the pending-rd mask it implies
    always_comb begin
        vld_d = fifo_vld_q;
        rd_d  = fifo_rd_q;
        if (pop) vld_d[rd_ptr_q] = 1'b0;
        if (push_store) begin
            vld_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]  = lu_rd;
        end
        mask_d = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_d[i]) mask_d[rd_d[i]] = 1'b1;
        end
        case ({push_store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt_q <= ADDR_W'(1);
            defer_q    <= '0;
            rf_we      <= 1'b0;
            rf_a3      <= '0;
            rf_wd3     <= '0;
            wb_stall   <= 1'b0;
            init_busy  <= 1'b1;
        end else begin
            init_cnt_q <= init_cnt_d;
            defer_q    <= defer_d;
            rf_we      <= rf_we_d;
            rf_a3      <= rf_a3_d;
            rf_wd3     <= rf_wd3_d;
            wb_stall   <= wb_stall_d;
            init_busy  <= init_busy_d;
        end
    end

    // LU write buffer storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_vld_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pending_mask <= '0;
        end else begin
            if (push_store) begin
                fifo_data_q[wr_ptr_q] <= lu_data;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_rd_q    <= rd_d;
            fifo_vld_q   <= vld_d;
            count_q      <= count_d;
            pending_mask <= mask_d;
        end
    end

endmodule
